decode_ctrl: RTL and testbench
==============================

Name: decode_ctrl

Overview:
Decode-stage controller for the 5-stage RV32I pipeline. Decodes the ID-stage instruction and drives imm_src_d to the immediate extender. Registers the EX-stage control bundle (ID/EX control register) and detects load-use hazards, producing stall and flush controls for the IF/ID registers. Also keeps a saturating count of load-use stall cycles for performance monitoring.

Parameters:
CNT_W, 16, width of the saturating load-use stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
instr_d  in  32  instruction in ID
valid_d  in  1  instr_d holds a real instruction (0 = bubble)
pc_src_e  in  1  taken branch or jump resolved in EX this cycle
imm_src_d  out  3  to extender: 000 I, 001 S, 010 B, 011 J, 100 U
reg_write_e  out  1  EX: instruction writes rd
result_src_e  out  2  EX: 00 ALU, 01 mem, 10 PC+4, 11 imm
mem_write_e  out  1  EX: store
branch_e  out  1  EX: conditional branch
jump_e  out  1  EX: jal/jalr
alu_src_e  out  1  EX: ALU operand B is imm
alu_op_e  out  2  EX: 00 add, 01 sub/compare, 10 funct-decoded
funct3_e  out  3  EX: funct3
funct7b5_e  out  1  EX: instr[30]
rd_e, rs1_e, rs2_e  out  5 each  EX register indices
valid_e  out  1  EX holds a real instruction
illegal_e  out  1  EX instruction had an unsupported opcode
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
flush_d  out  1  clear IF/ID register
stall_cnt  out  CNT_W  load-use stall cycles since reset, saturating

Behaviour:
- Combinational decode of instr_d[6:0]:
  lw 0000011: I, reg_write, result 01, alu_src, op 00.
  sw 0100011: S, mem_write, alu_src, op 00.
  R 0110011: reg_write, op 10.
  I-ALU 0010011: I, reg_write, alu_src, op 10.
  beq/bne/etc 1100011: B, branch, op 01.
  jal 1101111: J, reg_write, jump, result 10.
  jalr 1100111: I, reg_write, jump, result 10, alu_src, op 00.
  lui 0110111: U, reg_write, result 11.
  auipc 0010111: U, reg_write, alu_src, op 00.
  Any other opcode: imm_src 000, all enables 0, illegal flagged.
- imm_src_d is purely combinational from instr_d, independent of valid_d.
- Register-source usage:
  rs1 used by R, I-ALU, lw, sw, branch, jalr.
  rs2 used by R, sw, branch.
- lwstall = valid_e & result_src_e==01 & rd_e!=0 & valid_d & ((rs1 used & rs1_d==rd_e) | (rs2 used & rs2_d==rd_e)) & !pc_src_e.
- stall_f = stall_d = lwstall. flush_d = pc_src_e. All three are combinational.
- ID/EX register, updated every rising edge:
  - If !rst_n, or flush_e = lwstall | pc_src_e: load a bubble. All control bits 0, valid_e 0, illegal_e 0, indices 0.
  - Otherwise: load the decoded bundle. valid_e = valid_d. illegal_e = valid_d & unsupported opcode. Every write enable is gated by valid_d.
- The register always captures a new value; EX is never stalled by this block.
- Reset values: every registered output is 0. stall_cnt is 0. Combinational outputs follow their inputs; with a bubble in EX after reset, stall_f, stall_d and flush_d are 0 unless pc_src_e is driven.
- stall_cnt increments by 1 on each clock with lwstall=1 and rst_n=1. It holds at 2^CNT_W-1 (no wrap).
- Simultaneous pc_src_e and a hazard condition: the flush wins. No stall is asserted; the EX bubble is inserted and flush_d=1.
- Reset asserted mid-stall: the next edge clears EX to a bubble and clears stall_cnt; the stall deasserts that cycle.
- Latency: decode to EX outputs is 1 cycle. Hazard outputs are 0 cycles.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with an arbitrary instr_d, then release -> all EX outputs 0, valid_e=0, stall_cnt=0.
- Decode sweep: one instruction per opcode (e.g. sw x5,8(x2)=0x00512423, jal x1,16=0x010000EF) -> imm_src_d is 001 and 011 respectively; one cycle later the EX bundle matches the decode rules; opcode 0x7F -> illegal_e=1, reg_write_e=0.
- Load-use: lw x6,0(x1) then add x7,x6,x2 -> the cycle the add is in ID has stall_f=stall_d=1; the next EX is a bubble; the add enters EX one cycle later; stall_cnt=1.
- No false stall: lw x0,0(x1) followed by add x7,x0,x2; and lw x6 followed by lui x6 -> stall_f stays 0.
- Branch flush: pc_src_e=1 while a load-use condition is present -> flush_d=1, stall_f=0, next valid_e=0, stall_cnt unchanged.
- Saturation: CNT_W=2, force 5 consecutive load-use stalls -> stall_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/decode_ctrl_if.sv
// ID-stage / EX-stage control bus of the decode controller.
// master = pipeline side feeding ID, slave = decode_ctrl.
interface decode_ctrl_if #(parameter int CNT_W = 16);
  logic [31:0]      instr_d;
  logic             valid_d;
  logic             pc_src_e;
  logic [2:0]       imm_src_d;
  logic             reg_write_e;
  logic [1:0]       result_src_e;
  logic             mem_write_e;
  logic             branch_e;
  logic             jump_e;
  logic             alu_src_e;
  logic [1:0]       alu_op_e;
  logic [2:0]       funct3_e;
  logic             funct7b5_e;
  logic [4:0]       rd_e;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic             valid_e;
  logic             illegal_e;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output instr_d, valid_d, pc_src_e,
    input  imm_src_d, reg_write_e, result_src_e, mem_write_e, branch_e, jump_e,
           alu_src_e, alu_op_e, funct3_e, funct7b5_e, rd_e, rs1_e, rs2_e,
           valid_e, illegal_e, stall_f, stall_d, flush_d, stall_cnt
  );

  modport slave (
    input  instr_d, valid_d, pc_src_e,
    output imm_src_d, reg_write_e, result_src_e, mem_write_e, branch_e, jump_e,
           alu_src_e, alu_op_e, funct3_e, funct7b5_e, rd_e, rs1_e, rs2_e,
           valid_e, illegal_e, stall_f, stall_d, flush_d, stall_cnt
  );
endinterface

// File: rtl/decode_ctrl.sv
// RV32I decode-stage controller: opcode decode, ID/EX control register,
// load-use hazard detection with IF/ID stall/flush, saturating stall counter.
module decode_ctrl #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  decode_ctrl_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       use_rs1;
    logic       use_rs2;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ex_t;

  dec_t             dec;
  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rs1_d, rs2_d, rd_d;
  logic             ld_in_ex;
  logic             lwstall;
  logic             flush_e;

  assign rd_d  = bus.instr_d[11:7];
  assign rs1_d = bus.instr_d[19:15];
  assign rs2_d = bus.instr_d[24:20];

  // Opcode decode; unknown opcodes leave every enable low and flag illegal.
  always_comb begin
    dec = '0;
    unique case (bus.instr_d[6:0])
      OP_LOAD: begin
        dec.imm_src = IMM_I; dec.reg_write = 1'b1; dec.result_src = RES_MEM;
        dec.alu_src = 1'b1;  dec.alu_op = ALU_ADD; dec.use_rs1 = 1'b1;
      end
      OP_STORE: begin
        dec.imm_src = IMM_S; dec.mem_write = 1'b1; dec.alu_src = 1'b1;
        dec.alu_op = ALU_ADD; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
      end
      OP_R: begin
        dec.reg_write = 1'b1; dec.result_src = RES_ALU; dec.alu_op = ALU_FN;
        dec.use_rs1 = 1'b1;   dec.use_rs2 = 1'b1;
      end
      OP_IALU: begin
        dec.imm_src = IMM_I; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.alu_op = ALU_FN; dec.use_rs1 = 1'b1;
      end
      OP_BR: begin
        dec.imm_src = IMM_B; dec.branch = 1'b1; dec.alu_op = ALU_SUB;
        dec.use_rs1 = 1'b1;  dec.use_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec.imm_src = IMM_J; dec.reg_write = 1'b1; dec.jump = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_JALR: begin
        dec.imm_src = IMM_I; dec.reg_write = 1'b1; dec.jump = 1'b1;
        dec.result_src = RES_PC4; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD;
        dec.use_rs1 = 1'b1;
      end
      OP_LUI: begin
        dec.imm_src = IMM_U; dec.reg_write = 1'b1; dec.result_src = RES_IMM;
      end
      OP_AUIPC: begin
        dec.imm_src = IMM_U; dec.reg_write = 1'b1; dec.alu_src = 1'b1;
        dec.alu_op = ALU_ADD;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load-use hazard: a real load with a non-x0 target sits in EX and the
  // real instruction in ID reads that register. A redirect in EX overrides
  // the stall, since the ID instruction is being discarded anyway.
  always_comb begin
    ld_in_ex = ex_q.valid & (ex_q.result_src == RES_MEM) & (ex_q.rd != 5'd0);
    lwstall  = ld_in_ex & bus.valid_d & ~bus.pc_src_e &
               ((dec.use_rs1 & (rs1_d == ex_q.rd)) |
                (dec.use_rs2 & (rs2_d == ex_q.rd)));
    flush_e  = lwstall | bus.pc_src_e;
  end

  // Next ID/EX contents: bubble on stall or redirect, otherwise the decoded
  // bundle. Anything with a side effect (rd write, store, PC redirect) is
  // qualified by valid_d so an ID bubble can never act in EX.
  always_comb begin
    ex_d = '0;
    if (!flush_e) begin
      ex_d.valid      = bus.valid_d;
      ex_d.reg_write  = dec.reg_write & bus.valid_d;
      ex_d.result_src = dec.result_src;
      ex_d.mem_write  = dec.mem_write & bus.valid_d;
      ex_d.branch     = dec.branch & bus.valid_d;
      ex_d.jump       = dec.jump & bus.valid_d;
      ex_d.alu_src    = dec.alu_src;
      ex_d.alu_op     = dec.alu_op;
      ex_d.funct3     = bus.instr_d[14:12];
      ex_d.funct7b5   = bus.instr_d[30];
      ex_d.rd         = rd_d;
      ex_d.rs1        = rs1_d;
      ex_d.rs2        = rs2_d;
      ex_d.illegal    = dec.illegal & bus.valid_d;
    end
  end

  // ID/EX register; EX is never held, so it loads every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Saturating load-use stall counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (lwstall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.imm_src_d    = dec.imm_src;
  assign bus.reg_write_e  = ex_q.reg_write;
  assign bus.result_src_e = ex_q.result_src;
  assign bus.mem_write_e  = ex_q.mem_write;
  assign bus.branch_e     = ex_q.branch;
  assign bus.jump_e       = ex_q.jump;
  assign bus.alu_src_e    = ex_q.alu_src;
  assign bus.alu_op_e     = ex_q.alu_op;
  assign bus.funct3_e     = ex_q.funct3;
  assign bus.funct7b5_e   = ex_q.funct7b5;
  assign bus.rd_e         = ex_q.rd;
  assign bus.rs1_e        = ex_q.rs1;
  assign bus.rs2_e        = ex_q.rs2;
  assign bus.valid_e      = ex_q.valid;
  assign bus.illegal_e    = ex_q.illegal;
  assign bus.stall_f      = lwstall;
  assign bus.stall_d      = lwstall;
  assign bus.flush_d      = bus.pc_src_e;
  assign bus.stall_cnt    = cnt_q;

  // Instruction bits that only matter to the immediate extender / ALU decode.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, bus.instr_d[31], bus.instr_d[29:25]};

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: a wide-counter and a 2-bit-counter instance share
// stimulus; both are compared each cycle against a behavioural pipeline model.
module tb_decode_ctrl;
  logic clk;
  logic rst_n;

  decode_ctrl_if #(.CNT_W(16)) u_if ();
  decode_ctrl_if #(.CNT_W(2))  s_if ();

  assign s_if.instr_d  = u_if.instr_d;
  assign s_if.valid_d  = u_if.valid_d;
  assign s_if.pc_src_e = u_if.pc_src_e;

  decode_ctrl #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  decode_ctrl #(.CNT_W(2))  s_dut (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode table: what the ISA says each opcode needs.
  typedef struct {
    bit [2:0] imm; bit rw; bit [1:0] rsrc; bit mw; bit br; bit jmp;
    bit asrc; bit [1:0] aop; bit u1; bit u2; bit ill;
  } dec_t;

  // Expected EX contents, ordered like the observed concatenation below.
  typedef struct packed {
    bit valid; bit rw; bit [1:0] rsrc; bit mw; bit br; bit jmp; bit asrc;
    bit [1:0] aop; bit [2:0] f3; bit f7; bit [4:0] rd; bit [4:0] rs1;
    bit [4:0] rs2; bit ill;
  } ex_t;

  function automatic dec_t dec(input bit [6:0] op);
    dec_t d;
    case (op)
      7'h03:   d = '{3'd0, 1, 2'd1, 0, 0, 0, 1, 2'd0, 1, 0, 0};
      7'h23:   d = '{3'd1, 0, 2'd0, 1, 0, 0, 1, 2'd0, 1, 1, 0};
      7'h33:   d = '{3'd0, 1, 2'd0, 0, 0, 0, 0, 2'd2, 1, 1, 0};
      7'h13:   d = '{3'd0, 1, 2'd0, 0, 0, 0, 1, 2'd2, 1, 0, 0};
      7'h63:   d = '{3'd2, 0, 2'd0, 0, 1, 0, 0, 2'd1, 1, 1, 0};
      7'h6F:   d = '{3'd3, 1, 2'd2, 0, 0, 1, 0, 2'd0, 0, 0, 0};
      7'h67:   d = '{3'd0, 1, 2'd2, 0, 0, 1, 1, 2'd0, 1, 0, 0};
      7'h37:   d = '{3'd4, 1, 2'd3, 0, 0, 0, 0, 2'd0, 0, 0, 0};
      7'h17:   d = '{3'd4, 1, 2'd0, 0, 0, 0, 1, 2'd0, 0, 0, 0};
      default: d = '{3'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 1};
    endcase
    return d;
  endfunction

  ex_t m;
  int  cnt16, cnt2;
  int  n_chk, n_pass;

  // Per-step samples: combinational {imm,stall_f,stall_d,flush_d} before the
  // edge, EX bundle and counters after it.
  logic [5:0]  comb_obs, comb_exp;
  logic [29:0] ex_obs, ex_exp;
  logic [15:0] cnt_obs, cnt_exp;
  logic [1:0]  cnt2_obs, cnt2_exp;

  task automatic step(input logic [31:0] ins, input logic v, input logic pc, input logic rn);
    dec_t d;
    bit   hz;
    @(negedge clk);
    rst_n = rn; u_if.instr_d = ins; u_if.valid_d = v; u_if.pc_src_e = pc;
    #1;
    d  = dec(ins[6:0]);
    hz = m.valid && m.rsrc == 2'd1 && m.rd != 5'd0 && v && !pc &&
         ((d.u1 && ins[19:15] == m.rd) || (d.u2 && ins[24:20] == m.rd));
    comb_obs = {u_if.imm_src_d, u_if.stall_f, u_if.stall_d, u_if.flush_d};
    comb_exp = {d.imm, hz, hz, pc};
    if (!rn) begin
      m = '0; cnt16 = 0; cnt2 = 0;
    end else if (hz || pc) begin
      m = '0;
      if (hz && cnt16 < 65535) cnt16++;
      if (hz && cnt2 < 3) cnt2++;
    end else begin
      m = '{v, d.rw & v, d.rsrc, d.mw & v, d.br & v, d.jmp & v, d.asrc, d.aop,
            ins[14:12], ins[30], ins[11:7], ins[19:15], ins[24:20], d.ill & v};
    end
    @(posedge clk);
    #1;
    ex_obs = {u_if.valid_e, u_if.reg_write_e, u_if.result_src_e, u_if.mem_write_e,
              u_if.branch_e, u_if.jump_e, u_if.alu_src_e, u_if.alu_op_e, u_if.funct3_e,
              u_if.funct7b5_e, u_if.rd_e, u_if.rs1_e, u_if.rs2_e, u_if.illegal_e};
    ex_exp   = m;
    cnt_obs  = u_if.stall_cnt;
    cnt_exp  = 16'(cnt16);
    cnt2_obs = s_if.stall_cnt;
    cnt2_exp = 2'(cnt2);
  endtask

  localparam logic [31:0] LW_X6   = 32'h0000A303; // lw  x6,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD_X6  = 32'h002303B3; // add x7,x6,x2
  localparam logic [31:0] ADD_X0  = 32'h002003B3; // add x7,x0,x2
  localparam logic [31:0] LUI_X6  = 32'h12345337; // lui x6,0x12345
  localparam logic [31:0] SW_INS  = 32'h00512423; // sw  x5,8(x2)
  localparam logic [31:0] JAL_INS = 32'h010000EF; // jal x1,16

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step($urandom, 1'b1, 1'b0, 1'b0);
      n_chk++; if (ex_obs !== ex_exp) $display("FAIL reset_ex got %h want %h", ex_obs, ex_exp); else n_pass++;
      n_chk++; if (cnt_obs !== 16'd0) $display("FAIL reset_cnt got %0d want 0", cnt_obs); else n_pass++;
    end
    step(32'h0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (comb_obs[2:0] !== 3'b000) $display("FAIL reset_hazard got %b want 000", comb_obs[2:0]); else n_pass++;
    n_chk++; if (u_if.valid_e !== 1'b0) $display("FAIL reset_valid_e got %b want 0", u_if.valid_e); else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] prog [10] = '{LW_X6, SW_INS, ADD_X6, 32'h00508293, 32'h00208463,
                               JAL_INS, 32'h000280E7, LUI_X6, 32'h00001197, 32'h0000007F};
    step(32'h0, 1'b0, 1'b0, 1'b1);
    foreach (prog[i]) begin
      step(prog[i], 1'b1, 1'b0, 1'b1);
      n_chk++; if (comb_obs !== comb_exp) $display("FAIL decode_comb[%0d] got %h want %h", i, comb_obs, comb_exp); else n_pass++;
      n_chk++; if (ex_obs !== ex_exp) $display("FAIL decode_ex[%0d] got %h want %h", i, ex_obs, ex_exp); else n_pass++;
      if (prog[i] == SW_INS) begin
        n_chk++; if (comb_obs[5:3] !== 3'b001) $display("FAIL decode_sw_imm got %b want 001", comb_obs[5:3]); else n_pass++;
      end
      if (prog[i] == JAL_INS) begin
        n_chk++; if (comb_obs[5:3] !== 3'b011) $display("FAIL decode_jal_imm got %b want 011", comb_obs[5:3]); else n_pass++;
      end
    end
    n_chk++; if ({u_if.illegal_e, u_if.reg_write_e} !== 2'b10) $display("FAIL decode_illegal got %b want 10", {u_if.illegal_e, u_if.reg_write_e}); else n_pass++;
  endtask

  task automatic test_load_use();
    logic [15:0] c0;
    step(LW_X6, 1'b1, 1'b0, 1'b1);
    c0 = cnt_obs;
    step(ADD_X6, 1'b1, 1'b0, 1'b1);
    n_chk++; if (comb_obs[2:1] !== 2'b11) $display("FAIL lu_stall got %b want 11", comb_obs[2:1]); else n_pass++;
    n_chk++; if (u_if.valid_e !== 1'b0) $display("FAIL lu_bubble got %b want 0", u_if.valid_e); else n_pass++;
    n_chk++; if (cnt_obs !== c0 + 16'd1) $display("FAIL lu_cnt got %0d want %0d", cnt_obs, c0 + 16'd1); else n_pass++;
    step(ADD_X6, 1'b1, 1'b0, 1'b1);
    n_chk++; if (comb_obs[2:1] !== 2'b00) $display("FAIL lu_release got %b want 00", comb_obs[2:1]); else n_pass++;
    n_chk++; if ({u_if.valid_e, u_if.rd_e} !== 6'b1_00111) $display("FAIL lu_add_ex got %b want 100111", {u_if.valid_e, u_if.rd_e}); else n_pass++;
    n_chk++; if (ex_obs !== ex_exp) $display("FAIL lu_ex got %h want %h", ex_obs, ex_exp); else n_pass++;
  endtask

  task automatic test_no_false_stall();
    step(LW_X0, 1'b1, 1'b0, 1'b1);
    step(ADD_X0, 1'b1, 1'b0, 1'b1);
    n_chk++; if (comb_obs[2] !== 1'b0) $display("FAIL nfs_x0 got %b want 0", comb_obs[2]); else n_pass++;
    step(LW_X6, 1'b1, 1'b0, 1'b1);
    step(LUI_X6, 1'b1, 1'b0, 1'b1);
    n_chk++; if (comb_obs[2] !== 1'b0) $display("FAIL nfs_lui got %b want 0", comb_obs[2]); else n_pass++;
    n_chk++; if (ex_obs !== ex_exp) $display("FAIL nfs_ex got %h want %h", ex_obs, ex_exp); else n_pass++;
  endtask

  task automatic test_branch_flush();
    logic [15:0] c0;
    step(LW_X6, 1'b1, 1'b0, 1'b1);
    c0 = cnt_obs;
    step(ADD_X6, 1'b1, 1'b1, 1'b1);
    n_chk++; if (comb_obs[2:0] !== 3'b001) $display("FAIL bf_ctrl got %b want 001", comb_obs[2:0]); else n_pass++;
    n_chk++; if (u_if.valid_e !== 1'b0) $display("FAIL bf_valid_e got %b want 0", u_if.valid_e); else n_pass++;
    n_chk++; if (cnt_obs !== c0) $display("FAIL bf_cnt got %0d want %0d", cnt_obs, c0); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    step(LW_X6, 1'b1, 1'b0, 1'b1);
    step(ADD_X6, 1'b1, 1'b0, 1'b0);
    n_chk++; if (ex_obs !== 30'd0) $display("FAIL rms_ex got %h want 0", ex_obs); else n_pass++;
    n_chk++; if ({cnt_obs, cnt2_obs} !== 18'd0) $display("FAIL rms_cnt got %0d/%0d want 0/0", cnt_obs, cnt2_obs); else n_pass++;
    step(ADD_X6, 1'b1, 1'b0, 1'b1);
    n_chk++; if (comb_obs[2:1] !== 2'b00) $display("FAIL rms_stall got %b want 00", comb_obs[2:1]); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      step(LW_X6, 1'b1, 1'b0, 1'b1);
      step(ADD_X6, 1'b1, 1'b0, 1'b1);
      n_chk++; if (cnt2_obs !== want[i]) $display("FAIL sat_cnt2[%0d] got %0d want %0d", i, cnt2_obs, want[i]); else n_pass++;
      n_chk++; if (cnt_obs !== cnt_exp) $display("FAIL sat_cnt16[%0d] got %0d want %0d", i, cnt_obs, cnt_exp); else n_pass++;
      step(ADD_X6, 1'b1, 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [11] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F,
                             7'h67, 7'h37, 7'h17, 7'h7F, 7'h03};
    logic [31:0] ins;
    for (int i = 0; i < 400; i++) begin
      ins        = $urandom;
      ins[6:0]   = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 10)];
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      step(ins, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, 1'b1);
      n_chk++; if (comb_obs !== comb_exp) $display("FAIL rnd_comb[%0d] ins %h got %h want %h", i, ins, comb_obs, comb_exp); else n_pass++;
      n_chk++; if (ex_obs !== ex_exp) $display("FAIL rnd_ex[%0d] ins %h got %h want %h", i, ins, ex_obs, ex_exp); else n_pass++;
      n_chk++; if ({cnt_obs, cnt2_obs} !== {cnt_exp, cnt2_exp}) $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, cnt_obs, cnt2_obs, cnt_exp, cnt2_exp); else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m = '0; cnt16 = 0; cnt2 = 0;
    rst_n = 1'b0;
    u_if.instr_d = '0; u_if.valid_d = 1'b0; u_if.pc_src_e = 1'b0;
    test_reset();
    test_decode();
    test_load_use();
    test_no_false_stall();
    test_branch_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
